// File: rtl/regfile_pkg.sv
// Shared register-file write-port types and defaults for the writeback arbiters
// and the register file itself.
package regfile_pkg;

  localparam int unsigned NUM_REQ    = 8;
  localparam int unsigned SEL_W      = 3;
  localparam int unsigned DEF_ADDR_W = 5;
  localparam int unsigned DEF_DATA_W = 64;

  typedef logic [SEL_W-1:0] sel_t;

  typedef enum logic {
    ARB_IDLE,
    ARB_LOCKED
  } arb_state_e;

  function automatic logic [NUM_REQ-1:0] onehot8(input sel_t idx);
    return NUM_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/regfile_wr_arbiter_rr_pick8.sv
// Rotate-priority encoder: first set bit of req searching ptr, ptr+1, ... modulo 8.
module rr_pick8
  import regfile_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  sel_t               ptr,
  output logic               any,
  output sel_t               idx
);

  sel_t cand;

  always_comb begin
    any  = 1'b0;
    idx  = '0;
    cand = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = ptr + SEL_W'(k);
      if (!any && req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter for the register file's single write port, with optional
// per-owner burst lock; drives the 3-to-8 write-enable decoder plus addr/data.
module regfile_wr_arbiter
  import regfile_pkg::*;
#(
  parameter int unsigned ADDR_W    = DEF_ADDR_W,
  parameter int unsigned DATA_W    = DEF_DATA_W,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ-1:0]          req_lock,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          ready,
  output logic [SEL_W-1:0]            wr_sel,
  output logic                        wr_en,
  output logic [ADDR_W-1:0]           wr_addr,
  output logic [DATA_W-1:0]           wr_data,
  output logic                        owner_valid
);

  localparam int unsigned CNT_W = 4;

  arb_state_e        state_q, state_d;
  sel_t              owner_q, owner_d;
  sel_t              ptr_q, ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              wr_en_q, wr_en_d;
  sel_t              wr_sel_q, wr_sel_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              owner_valid_q, owner_valid_d;

  logic pick_any;
  sel_t pick_idx;
  logic accept;
  sel_t win;

  rr_pick8 u_pick (
    .req (req),
    .ptr (ptr_q),
    .any (pick_any),
    .idx (pick_idx)
  );

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    ptr_d         = ptr_q;
    cnt_d         = cnt_q;
    wr_sel_d      = wr_sel_q;
    wr_addr_d     = wr_addr_q;
    wr_data_d     = wr_data_q;
    owner_valid_d = owner_valid_q;
    accept        = 1'b0;
    win           = pick_idx;

    // While locked only the owner may be served; the rotating search is bypassed.
    if (state_q == ARB_IDLE) begin
      accept = pick_any;
      win    = pick_idx;
    end else begin
      accept = req[owner_q];
      win    = owner_q;
    end

    ready   = accept ? onehot8(win) : '0;
    wr_en_d = accept;

    if (accept) begin
      wr_sel_d  = win;
      wr_addr_d = req_addr[int'(win)*ADDR_W +: ADDR_W];
      wr_data_d = req_data[int'(win)*DATA_W +: DATA_W];
    end

    case (state_q)
      ARB_IDLE: begin
        if (accept) begin
          if (req_lock[win] && (MAX_BURST > 1)) begin
            state_d       = ARB_LOCKED;
            owner_d       = win;
            cnt_d         = CNT_W'(1);
            owner_valid_d = 1'b1;
          end else begin
            ptr_d = win + SEL_W'(1);
          end
        end
      end
      ARB_LOCKED: begin
        // A missing owner request or the burst limit both release the lock.
        if (accept && req_lock[owner_q] && ((int'(cnt_q) + 1) < int'(MAX_BURST))) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          state_d       = ARB_IDLE;
          ptr_d         = owner_q + SEL_W'(1);
          cnt_d         = '0;
          owner_valid_d = 1'b0;
        end
      end
      default: begin
        state_d       = ARB_IDLE;
        cnt_d         = '0;
        owner_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ARB_IDLE;
      owner_q       <= '0;
      ptr_q         <= '0;
      cnt_q         <= '0;
      wr_en_q       <= 1'b0;
      wr_sel_q      <= '0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      owner_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      ptr_q         <= ptr_d;
      cnt_q         <= cnt_d;
      wr_en_q       <= wr_en_d;
      wr_sel_q      <= wr_sel_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      owner_valid_q <= owner_valid_d;
    end
  end

  assign wr_en       = wr_en_q;
  assign wr_sel      = wr_sel_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign owner_valid = owner_valid_q;

endmodule

// File: doc/regfile_wr_arbiter.md
Name: regfile_wr_arbiter

Overview:
- Shares the register file's single write port among 8 requesters (ALU, load unit, link, etc.) with round-robin fairness and optional burst lock.
- Produces a registered 3-bit select plus enable that feed the existing 3-to-8 write-enable decoder.
- Also produces the registered write address and data for the register file.
- Sits between the execute/writeback stages and the register file.

Parameters:
- NUM_REQ, 8, number of requesters; fixed at 8 to match the decoder width.
- ADDR_W, 5, register address width.
- DATA_W, 64, register data width.
- MAX_BURST, 4, maximum consecutive accepted beats per locked owner; legal range 1..15.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req  in  8  per-requester write request.
- req_lock  in  8  requester asks to retain ownership after this beat.
- req_addr  in  8*ADDR_W  packed per-requester register address; slot i is bits [i*ADDR_W +: ADDR_W].
- req_data  in  8*DATA_W  packed per-requester write data.
- ready  out  8  one-hot or zero, combinational; a beat is accepted when req[i] & ready[i] at a clock edge.
- wr_sel  out  3  registered index of the accepted requester; drives the decoder input.
- wr_en  out  1  registered; drives the decoder enable.
- wr_addr  out  ADDR_W  registered address of the accepted beat.
- wr_data  out  DATA_W  registered data of the accepted beat.
- owner_valid  out  1  registered; high while a lock is held.

Behaviour:
- Reset (async assert, any cycle, including mid-burst):
  - wr_en=0, wr_sel=0, wr_addr=0, wr_data=0, owner_valid=0.
  - Pointer ptr=0, burst count cnt=0, state IDLE.
  - Release is synchronous to clk.
- State IDLE: winner = first i with req[i]=1, searching ptr, ptr+1, … mod 8 (wrap 7→0).
  - ready = onehot(winner), or 0 if req == 0.
- State LOCKED(owner o):
  - ready = onehot(o) if req[o]=1; all other ready bits are 0.
  - If req[o]=0, ready = 0 and the lock drops at the next edge (see Transitions).
- Accept at edge, winner w:
  - wr_en<=1, wr_sel<=w, wr_addr<=req_addr[w], wr_data<=req_data[w].
  - Latency is one cycle from accept to the write appearing at the decoder.
- No accept at edge: wr_en<=0; wr_sel, wr_addr and wr_data hold their previous values.
- Transitions:
  - IDLE, accept w, req_lock[w]=1, MAX_BURST>1: go to LOCKED(w), cnt<=1, owner_valid<=1, ptr unchanged.
  - IDLE, accept w, no lock (or MAX_BURST=1): stay IDLE, ptr<=(w+1) mod 8.
  - LOCKED, accept, req_lock[o]=1, cnt+1 < MAX_BURST: stay LOCKED, cnt<=cnt+1.
  - LOCKED, accept, and either req_lock[o]=0 or cnt+1 == MAX_BURST: go to IDLE, ptr<=(o+1) mod 8, cnt<=0, owner_valid<=0.
  - LOCKED, req[o]=0: go to IDLE, ptr<=(o+1) mod 8, cnt<=0, owner_valid<=0. No write this cycle; other requesters are not served until the following cycle.
- Simultaneous requests: exactly one accept per cycle. A requester may wait at most 7 accepts in IDLE, plus MAX_BURST-1 per locked owner ahead of it.
- req_lock is ignored when req is low or the requester is not accepted.
- Address 0 gets no special treatment; zero-register suppression belongs to the register file.
- Requesters must hold req, req_addr and req_data stable until accepted; the arbiter does not check this.

Decomposition:
- Package regfile_pkg holds:
  - constants NUM_REQ=8 and SEL_W=3;
  - typedef sel_t (logic [2:0]);
  - enum arb_state_e {ARB_IDLE, ARB_LOCKED};
  - the ADDR_W/DATA_W defaults shared with the register file.
- One sub-module: rr_pick8, a combinational rotate-priority encoder.
  - Inputs: req[7:0], ptr[2:0].
  - Outputs: any, idx[2:0].
  - Reusable by other arbiters.

Test Plan:
- Reset then idle: assert reset_n=0 mid-simulation, req=8'h00 → all outputs 0, ready=0. Release, keep req=0 for 5 cycles → wr_en stays 0.
- Single requester: req=8'b0000_0100, addr=7, data=64'hDEAD → ready=8'h04. Next cycle wr_en=1, wr_sel=3'd2, wr_addr=7, wr_data=64'hDEAD; ptr becomes 3.
- Round-robin fairness: req=8'hFF held for 10 cycles from ptr=0 → wr_sel sequence 0,1,2,3,4,5,6,7,0,1 with wr_en=1 every cycle. Wrap from 7 to 0 verified.
- Burst lock: MAX_BURST=4; requester 5 with req_lock=1 held, and requester 1 also requesting → four consecutive writes with wr_sel=5, owner_valid high for 3 cycles. Then wr_sel=1, because ptr=6 wraps to 1.
- Lock with requester dropping out: requester 3 locked, req[3] falls after 2 beats while req[6]=1 → one cycle with wr_en=0, then wr_sel=6.
- Reset mid-burst: requester 2 locked at cnt=2, assert reset_n=0 → same cycle wr_en=0 and owner_valid=0. After release with req=8'h05 → wr_sel=0 first (ptr=0).
